// File: rtl/track_pkg.sv
// Shared codes for the line-follower decision stage and the motor block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the 5-bit mode codes, which the motor block decodes into speed and
// direction, plus the route table direction codes.
package track_pkg;

   // Mode codes; the FSM state encoding is identical to these values.
   localparam logic [4:0] MODE_IDLE     = 5'd0;
   localparam logic [4:0] MODE_START    = 5'd1;
   localparam logic [4:0] MODE_COUNT    = 5'd2;
   localparam logic [4:0] MODE_STRAIGHT = 5'd3;
   localparam logic [4:0] MODE_CHOOSE   = 5'd4;
   localparam logic [4:0] MODE_LEFT     = 5'd5;
   localparam logic [4:0] MODE_RIGHT    = 5'd6;
   localparam logic [4:0] MODE_BACK     = 5'd7;
   localparam logic [4:0] MODE_STOP     = 5'd30;
   localparam logic [4:0] MODE_ERROR    = 5'd31;

   // Route table direction codes.
   localparam logic [1:0] DIR_STRAIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT     = 2'b01;
   localparam logic [1:0] DIR_RIGHT    = 2'b10;
   localparam logic [1:0] DIR_BACK     = 2'b11;

   typedef enum logic [4:0] {
      ST_IDLE     = MODE_IDLE,
      ST_START    = MODE_START,
      ST_COUNT    = MODE_COUNT,
      ST_STRAIGHT = MODE_STRAIGHT,
      ST_CHOOSE   = MODE_CHOOSE,
      ST_LEFT     = MODE_LEFT,
      ST_RIGHT    = MODE_RIGHT,
      ST_BACK     = MODE_BACK,
      ST_STOP     = MODE_STOP,
      ST_ERROR    = MODE_ERROR
   } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// One-bit sensor debounce filter.
// Latency: filtered bit follows raw after DEBOUNCE_CYC identical samples.
// Backpressure: none; free-running sampled input.
//
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous active-high reset (filtered bit and counter to 0)
//   i_raw  - raw sensor bit
//   o_filt - debounced bit
module sensor_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_filt
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_filt;

   // The counter only runs while raw disagrees with the filtered bit; for a
   // single bit that means consecutive samples are all the same new value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else if (i_raw == r_filt) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_filt <= i_raw;
         r_cnt  <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_filt = r_filt;

endmodule

// File: rtl/track_mode_fsm.sv
// Line-follower decision FSM producing the motor mode code.
// Latency: mode changes one cycle after the deciding filtered sensor value.
// Backpressure: none; start pulses outside IDLE/STOP/ERROR are ignored.
//
// Ports:
//   i_clk       - system clock (100 MHz)
//   i_rst       - synchronous active-high reset
//   i_start     - single-cycle start/acknowledge pulse
//   i_sensor    - raw IR bits {left, mid, right}, 1 = line
//   i_route_dir - direction for the current junction from the route table
//   o_junc_idx  - junctions taken so far (route table address), saturates at 15
//   o_mode      - registered mode code (equals the state encoding)
//   o_busy      - high in every state except IDLE, STOP and ERROR
//
// Optional macro TRACK_RETRY_EN: the first turn timeout since the last
// junction retries with BACK instead of going to ERROR.
module track_mode_fsm
   import track_pkg::*;
#(
   parameter int CNT_CYC      = 300_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LOST_CYC     = 50_000_000,
   parameter int CHOOSE_CYC   = 20_000_000,
   parameter int TURN_MAX_CYC = 200_000_000,
   parameter int NUM_JUNC     = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [2:0] i_sensor,
   input  logic [1:0] i_route_dir,
   output logic [3:0] o_junc_idx,
   output logic [4:0] o_mode,
   output logic       o_busy
);

   // Only one duration is ever live at a time, so a single state timer sized
   // for the longest one serves COUNT, lost-line, CHOOSE and turn timeouts.
   localparam int MAX_A   = (CNT_CYC > LOST_CYC) ? CNT_CYC : LOST_CYC;
   localparam int MAX_B   = (CHOOSE_CYC > TURN_MAX_CYC) ? CHOOSE_CYC : TURN_MAX_CYC;
   localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] CNT_LAST    = TMR_W'(CNT_CYC - 1);
   localparam logic [TMR_W-1:0] LOST_LAST   = TMR_W'(LOST_CYC - 1);
   localparam logic [TMR_W-1:0] CHOOSE_LAST = TMR_W'(CHOOSE_CYC - 1);
   localparam logic [TMR_W-1:0] TURN_LAST   = TMR_W'(TURN_MAX_CYC - 1);
   localparam logic [3:0]       JUNC_END    = 4'(NUM_JUNC);

   logic [2:0]       w_f;        // filtered {left, mid, right}
   state_t           r_state;
   logic [TMR_W-1:0] r_tmr;
   logic [3:0]       r_junc;
   logic [1:0]       r_dir;      // route direction latched at the junction
   logic             r_corr;     // LEFT/RIGHT is a line correction, not a turn
   logic             r_phase_b;  // turn has left the line, now seeking it
   logic             r_busy;
`ifdef TRACK_RETRY_EN
   logic             r_retry;    // a timeout retry was already used
`endif

   for (genvar g = 0; g < 3; g++) begin : g_db
      sensor_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_db (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_raw  (i_sensor[g]),
         .o_filt (w_f[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_tmr     <= '0;
         r_junc    <= '0;
         r_dir     <= DIR_STRAIGHT;
         r_corr    <= 1'b0;
         r_phase_b <= 1'b0;
         r_busy    <= 1'b0;
`ifdef TRACK_RETRY_EN
         r_retry   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_START;
                  r_busy  <= 1'b1;
                  r_junc  <= '0;
               end
            end

            ST_START: begin
               r_state <= ST_COUNT;
               r_tmr   <= '0;
            end

            ST_COUNT: begin
               if (r_tmr == CNT_LAST) begin
                  r_state <= ST_STRAIGHT;
                  r_tmr   <= '0;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end

            ST_STRAIGHT: begin
               // Timer doubles as the lost-line counter; any non-000 clears it.
               r_tmr <= '0;
               if (w_f == 3'b111) begin
                  r_state <= ST_CHOOSE;
                  r_dir   <= i_route_dir;
                  if (r_junc != 4'hF) r_junc <= r_junc + 1'b1;
`ifdef TRACK_RETRY_EN
                  r_retry <= 1'b0;
`endif
               end else if (w_f == 3'b101) begin
                  r_state <= ST_ERROR;
                  r_busy  <= 1'b0;
               end else if (w_f == 3'b100 || w_f == 3'b110) begin
                  r_state <= ST_LEFT;
                  r_corr  <= 1'b1;
               end else if (w_f == 3'b001 || w_f == 3'b011) begin
                  r_state <= ST_RIGHT;
                  r_corr  <= 1'b1;
               end else if (w_f == 3'b000) begin
                  if (r_tmr == LOST_LAST) begin
                     r_state   <= ST_BACK;
                     r_corr    <= 1'b0;
                     r_phase_b <= 1'b0;
                  end else begin
                     r_tmr <= r_tmr + 1'b1;
                  end
               end
            end

            ST_CHOOSE: begin
               if (r_junc == JUNC_END) begin
                  r_state <= ST_STOP;
                  r_busy  <= 1'b0;
               end else if (r_tmr == CHOOSE_LAST) begin
                  r_tmr     <= '0;
                  r_corr    <= 1'b0;
                  r_phase_b <= 1'b0;
                  case (r_dir)
                     DIR_STRAIGHT: r_state <= ST_STRAIGHT;
                     DIR_LEFT:     r_state <= ST_LEFT;
                     DIR_RIGHT:    r_state <= ST_RIGHT;
                     default:      r_state <= ST_BACK;
                  endcase
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end

            ST_LEFT, ST_RIGHT, ST_BACK: begin
               // Completion wins over a timeout landing on the same cycle.
               if (r_corr && w_f == 3'b010) begin
                  r_state <= ST_STRAIGHT;
                  r_tmr   <= '0;
               end else if (!r_corr && r_phase_b && w_f[1]) begin
                  r_state <= ST_STRAIGHT;
                  r_tmr   <= '0;
               end else if (r_tmr == TURN_LAST) begin
`ifdef TRACK_RETRY_EN
                  if (!r_retry) begin
                     r_state   <= ST_BACK;
                     r_retry   <= 1'b1;
                     r_tmr     <= '0;
                     r_corr    <= 1'b0;
                     r_phase_b <= 1'b0;
                  end else begin
                     r_state <= ST_ERROR;
                     r_busy  <= 1'b0;
                  end
`else
                  r_state <= ST_ERROR;
                  r_busy  <= 1'b0;
`endif
               end else begin
                  r_tmr <= r_tmr + 1'b1;
                  if (!r_corr && !w_f[1]) r_phase_b <= 1'b1;
               end
            end

            ST_STOP, ST_ERROR: begin
               if (i_start) r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_mode     = r_state;
   assign o_junc_idx = r_junc;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_track_mode_fsm.sv
// Directed bench for track_mode_fsm with short timing parameters.
module tb_track_mode_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] sensor;
   logic [1:0] route_dir;
   logic [3:0] junc_idx;
   logic [4:0] mode;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   track_mode_fsm #(
      .CNT_CYC      (20),
      .DEBOUNCE_CYC (4),
      .LOST_CYC     (16),
      .CHOOSE_CYC   (8),
      .TURN_MAX_CYC (64),
      .NUM_JUNC     (2)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_sensor    (sensor),
      .i_route_dir (route_dir),
      .o_junc_idx  (junc_idx),
      .o_mode      (mode),
      .o_busy      (busy)
   );

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sensor = 3'b010; route_dir = 2'b00;

      // 1: reset, start, countdown
      step(2);
      chk("rst_mode", 32'(mode), 0);
      chk("rst_junc", 32'(junc_idx), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0; start = 1'b1;
      step(1);
      chk("start_mode", 32'(mode), 1);
      chk("start_busy", 32'(busy), 1);
      start = 1'b0;
      step(1);
      chk("count_mode", 32'(mode), 2);
      start = 1'b1;              // must be ignored in COUNT
      step(1);
      start = 1'b0;
      step(18);
      chk("count_end", 32'(mode), 2);
      step(1);
      chk("straight1", 32'(mode), 3);

      // 2: correction left and back
      sensor = 3'b110;
      step(4);
      chk("corr_hold", 32'(mode), 3);
      step(1);
      chk("corr_left", 32'(mode), 5);
      sensor = 3'b010;
      step(4);
      chk("corr_still", 32'(mode), 5);
      step(1);
      chk("corr_done", 32'(mode), 3);

      // 3: junction 1, route right turn
      sensor = 3'b111; route_dir = 2'b10;
      step(5);
      chk("j1_choose", 32'(mode), 4);
      chk("j1_idx", 32'(junc_idx), 1);
      step(7);
      chk("j1_wait", 32'(mode), 4);
      step(1);
      chk("j1_right", 32'(mode), 6);
      sensor = 3'b000;
      step(5);
      chk("j1_phase", 32'(mode), 6);
      sensor = 3'b010;
      step(4);
      chk("j1_seek", 32'(mode), 6);
      step(1);
      chk("j1_done", 32'(mode), 3);

      // 4: junction 2 reaches NUM_JUNC -> STOP
      sensor = 3'b111;
      step(5);
      chk("j2_choose", 32'(mode), 4);
      chk("j2_idx", 32'(junc_idx), 2);
      step(1);
      chk("stop_mode", 32'(mode), 30);
      chk("stop_busy", 32'(busy), 0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("stop_idle", 32'(mode), 0);

      // 5: dead end -> BACK -> timeout
      sensor = 3'b010;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("restart_idx", 32'(junc_idx), 0);
      step(21);
      chk("straight2", 32'(mode), 3);
      sensor = 3'b000;
      step(19);
      chk("lost_hold", 32'(mode), 3);
      step(1);
      chk("lost_back", 32'(mode), 7);
      step(63);
      chk("back_hold", 32'(mode), 7);
      step(1);
`ifdef TRACK_RETRY_EN
      chk("retry_back", 32'(mode), 7);
      step(64);
`endif
      chk("timeout_err", 32'(mode), 31);
      chk("err_busy", 32'(busy), 0);

      // 6: glitch immunity, then reset in LEFT
      sensor = 3'b010;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("err_idle", 32'(mode), 0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(21);
      chk("straight3", 32'(mode), 3);
      sensor = 3'b111;
      step(1);
      sensor = 3'b010;
      step(6);
      chk("glitch_mode", 32'(mode), 3);
      chk("glitch_idx", 32'(junc_idx), 0);
      sensor = 3'b111; route_dir = 2'b01;
      step(5);
      chk("j3_choose", 32'(mode), 4);
      step(8);
      chk("j3_left", 32'(mode), 5);
      chk("j3_idx", 32'(junc_idx), 1);
      rst = 1'b1;
      step(1);
      chk("midrst_mode", 32'(mode), 0);
      chk("midrst_idx", 32'(junc_idx), 0);
      chk("midrst_busy", 32'(busy), 0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
